softmax_renorm_scheduler: RTL and testbench
===========================================

Name: softmax_renorm_scheduler

Overview:
Round-robin scheduler that shares one 32-element softmax renormalization engine among NUM_REQ row requesters, e.g. the per-row softmax cores behind the systolic array. It accepts one vector per valid/ready handshake and latches it. It then issues the vector to the engine with a single-cycle valid, waits for the engine's done pulse, and returns the result tagged with the requester ID. Exactly one vector is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
N, 32, elements per vector
BIT_WIDTH, 16, element width (Q0.16)
ID_W, 2, requester ID width; must equal clog2(NUM_REQ)
TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  [NUM_REQ]  requester k has a vector pending
i_req_data  in  [NUM_REQ][N] x BIT_WIDTH  per-requester vectors
o_req_ready  out  [NUM_REQ]  one-hot accept strobe
o_eng_valid  out  1  engine start pulse
o_eng_data  out  [N] x BIT_WIDTH  vector presented to the engine
i_eng_valid  in  1  engine done pulse
i_eng_data  in  [N] x BIT_WIDTH  engine normalized output
o_rsp_valid  out  1  result available
i_rsp_ready  in  1  consumer accepts the result
o_rsp_id  out  ID_W  requester that owns the result
o_rsp_data  out  [N] x BIT_WIDTH  normalized vector
o_rsp_err  out  1  result is invalid (timeout)
o_busy  out  1  state != IDLE
o_err_spurious  out  1  sticky flag: i_eng_valid seen outside WAIT

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces:
  - state=IDLE, rr_ptr=0;
  - all outputs 0, including vector buffers and o_err_spurious.
- Reset mid-operation abandons the in-flight vector; no response is produced. The engine shares i_rst_n polarity through its wrapper.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first k with i_req_valid[k], searching from rr_ptr upward modulo NUM_REQ.
  - o_req_ready = onehot(grant), combinational, only when some request is valid; 0 in all other states.
  - On a handshake: latch i_req_data[grant] into vec_buf, store grant_id, set rr_ptr = (grant+1) mod NUM_REQ, go to ISSUE.
- ISSUE: o_eng_valid=1 for exactly one cycle; go to WAIT.
- o_eng_data = vec_buf continuously; stable from ISSUE until the next grant.
- WAIT:
  - On i_eng_valid: capture i_eng_data into res_buf, go to RESP.
  - Otherwise hold.
- RESP:
  - o_rsp_valid=1, o_rsp_id=grant_id, o_rsp_data=res_buf.
  - All three are held stable until i_rsp_ready.
  - On the handshake cycle go to IDLE. New grants are possible from the next cycle.
- Minimum latency: handshake at cycle T, then o_eng_valid at T+1, then o_rsp_valid at (engine done)+1.
- i_eng_valid in IDLE/ISSUE/RESP: ignored for data and sets o_err_spurious (sticky until reset).
- Requests arriving during ISSUE/WAIT/RESP wait. i_req_valid may deassert before being granted; such a request is simply not granted.
- i_req_data[k] need only be stable on the handshake cycle.
- rr_ptr wraps from NUM_REQ-1 to 0. With a single requester valid, that requester is granted every round.
- o_rsp_err=0 whenever the optional feature is absent.

Optional Feature:
RENORM_SCHED_TIMEOUT_EN:
- Defined:
  - A WAIT cycle counter clears on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES without i_eng_valid: res_buf=0, o_rsp_err=1, go to RESP.
  - o_rsp_err clears on the RESP handshake.
  - A late i_eng_valid after the timeout sets o_err_spurious.
- Undefined: no counter logic; WAIT holds indefinitely and o_rsp_err is tied 0.

Test Plan:
- Single request: requester 2 sends all elements 0x0800. Expect o_req_ready=4'b0100 at T, o_eng_valid at T+1, then o_rsp_valid with id=2 and data 0x0800±1 LSB. The bench engine model divides each element by the Q0.16 sum.
- Fairness: all 4 requesters held valid for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3 and 2 responses per ID.
- Backpressure: i_rsp_ready=0 for 10 cycles in RESP. Expect o_rsp_valid/id/data stable, o_req_ready=0 and no o_eng_valid; one cycle after ready, IDLE grants the next request.
- Spurious done: pulse i_eng_valid in IDLE. Expect o_err_spurious=1 and held; the next transaction completes normally.
- Reset in WAIT: assert i_rst_n=0 for 2 cycles. Expect outputs 0 immediately (async), state IDLE, rr_ptr=0, no response; afterwards requester 0 wins when all are valid.
- Timeout (macro defined, TIMEOUT_CYCLES=16): engine never responds. Expect o_rsp_valid with o_rsp_err=1 and data all 0 at WAIT entry+16; with the macro undefined, o_busy=1 indefinitely.

Source files
------------

// File: rtl/softmax_renorm_scheduler_if.sv
// Bus bundle for softmax_renorm_scheduler.
// The master modport is the scheduler view; slave is the requester/engine/consumer side.
interface softmax_renorm_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int N         = 32,
  parameter int BIT_WIDTH = 16,
  parameter int ID_W      = 2
);
  logic [NUM_REQ-1:0]                     i_req_valid;
  logic [NUM_REQ-1:0][N-1:0][BIT_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]                     o_req_ready;
  logic                                   o_eng_valid;
  logic [N-1:0][BIT_WIDTH-1:0]            o_eng_data;
  logic                                   i_eng_valid;
  logic [N-1:0][BIT_WIDTH-1:0]            i_eng_data;
  logic                                   o_rsp_valid;
  logic                                   i_rsp_ready;
  logic [ID_W-1:0]                        o_rsp_id;
  logic [N-1:0][BIT_WIDTH-1:0]            o_rsp_data;
  logic                                   o_rsp_err;
  logic                                   o_busy;
  logic                                   o_err_spurious;

  modport master (
    input  i_req_valid, i_req_data, i_eng_valid, i_eng_data, i_rsp_ready,
    output o_req_ready, o_eng_valid, o_eng_data, o_rsp_valid, o_rsp_id,
    output o_rsp_data, o_rsp_err, o_busy, o_err_spurious
  );

  modport slave (
    output i_req_valid, i_req_data, i_eng_valid, i_eng_data, i_rsp_ready,
    input  o_req_ready, o_eng_valid, o_eng_data, o_rsp_valid, o_rsp_id,
    input  o_rsp_data, o_rsp_err, o_busy, o_err_spurious
  );
endinterface

// File: rtl/softmax_renorm_scheduler.sv
// Round-robin scheduler sharing one softmax renorm engine among NUM_REQ rows.
// Optional WAIT watchdog: define RENORM_SCHED_TIMEOUT_EN.
module softmax_renorm_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int N              = 32,
  parameter int BIT_WIDTH      = 16,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  softmax_renorm_scheduler_if.master bus
);

  localparam int IW = ID_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef logic [N-1:0][BIT_WIDTH-1:0] vec_t;

  state_t          state;
  state_t          state_n;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] next_ptr;
  logic [IW-1:0]   idx;
  logic            any_req;
  vec_t            vec_buf;
  vec_t            res_buf;
  logic            err_spur;
  logic            timeout;
  logic            rsp_err;

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + IW'(i);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      if (!any_req && bus.i_req_valid[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        grant   = idx[ID_W-1:0];
      end
    end
  end

  assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (any_req) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT:  if (bus.i_eng_valid || timeout) state_n = RESP;
      RESP:  if (bus.i_rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake strobes decoded from the state.
  always_comb begin
    bus.o_req_ready = '0;
    bus.o_eng_valid = 1'b0;
    bus.o_rsp_valid = 1'b0;
    unique case (state)
      IDLE:  if (any_req) bus.o_req_ready[grant] = 1'b1;
      ISSUE: bus.o_eng_valid = 1'b1;
      RESP:  bus.o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Grant bookkeeping, vector/result buffers and the spurious-done flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      vec_buf  <= '0;
      res_buf  <= '0;
      err_spur <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        vec_buf  <= bus.i_req_data[grant];
        grant_id <= grant;
        rr_ptr   <= next_ptr;
      end
      if (state == WAIT && bus.i_eng_valid) begin
        res_buf <= bus.i_eng_data;
      end
`ifdef RENORM_SCHED_TIMEOUT_EN
      else if (state == WAIT && timeout) begin
        res_buf <= '0;
      end
`endif
      if (bus.i_eng_valid && state != WAIT) err_spur <= 1'b1;
    end
  end

`ifdef RENORM_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles; a timed-out result is flagged until consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == WAIT && !bus.i_eng_valid && timeout) rsp_err <= 1'b1;
      else if (state == RESP && bus.i_rsp_ready) rsp_err <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  assign bus.o_eng_data     = vec_buf;
  assign bus.o_rsp_id       = grant_id;
  assign bus.o_rsp_data     = res_buf;
  assign bus.o_rsp_err      = rsp_err;
  assign bus.o_busy         = (state != IDLE);
  assign bus.o_err_spurious = err_spur;

endmodule

// File: tb/tb_softmax_renorm_scheduler.sv
// Testbench for softmax_renorm_scheduler: directed vectors plus a
// transaction-level model checked every cycle.
module tb_softmax_renorm_scheduler;

  localparam int NR  = 4;
  localparam int N   = 32;
  localparam int BW  = 16;
  localparam int IDW = 2;
  localparam int TO  = 16;

  typedef logic [N-1:0][BW-1:0] vec_t;
  typedef struct {
    logic [IDW-1:0] id;
    vec_t           v;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  softmax_renorm_scheduler_if #(
    .NUM_REQ(NR), .N(N), .BIT_WIDTH(BW), .ID_W(IDW)
  ) bus ();

  softmax_renorm_scheduler #(
    .NUM_REQ(NR), .N(N), .BIT_WIDTH(BW), .ID_W(IDW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  logic eng_done = 1'b0;
  logic spur = 1'b0;
  vec_t eng_out = '0;
  bit   eng_hang = 1'b0;

  assign bus.i_eng_valid = eng_done | spur;
  assign bus.i_eng_data  = eng_out;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t norm(vec_t v);
    vec_t r;
    longint s;
    s = 0;
    r = '0;
    for (int e = 0; e < N; e++) s += longint'(v[e]);
    for (int e = 0; e < N; e++)
      if (s != 0) r[e] = BW'((longint'(v[e]) * 65536) / s);
    return r;
  endfunction

  function automatic vec_t pat(int k, int r);
    vec_t v;
    for (int e = 0; e < N; e++)
      v[e] = BW'((k * 4099 + r * 257 + e * 97 + 1) & 16'hFFFF);
    return v;
  endfunction

  // Engine: one done pulse a cycle after each start, carrying the normalized vector.
  initial begin
    vec_t cap;
    forever begin
      @(negedge clk);
      if (bus.o_eng_valid && !eng_hang) begin
        cap = bus.o_eng_data;
        @(posedge clk);
        #1;
        eng_out  = norm(cap);
        eng_done = 1'b1;
        @(posedge clk);
        #1;
        eng_done = 1'b0;
      end
    end
  end

  txn_t q[$];
  int   m_ptr = 0;
  bit   m_issue = 0;
  bit   m_wait = 0;
  bit   m_resp = 0;
  bit   m_spur = 0;
  bit   m_err = 0;
  int   m_cnt = 0;

  // Compare process: transaction model of arbitration and the response flow.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    int g;
    bit resp_now;
    if (!rst_n) begin
      q.delete();
      m_ptr = 0; m_issue = 0; m_wait = 0;
      m_resp = 0; m_spur = 0; m_err = 0; m_cnt = 0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (q.size() == 0)
        for (int i = 0; i < NR; i++)
          if (g < 0 && bus.i_req_valid[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("m_req_ready", 512'(bus.o_req_ready), 512'(exp_rdy));
      chk("m_busy", 512'(bus.o_busy), 512'(q.size() != 0));
      chk("m_err_spurious", 512'(bus.o_err_spurious), 512'(m_spur));
      chk("m_eng_valid", 512'(bus.o_eng_valid), 512'(m_issue));
      if (m_issue) chk("m_eng_data", 512'(bus.o_eng_data), 512'(q[0].v));
      chk("m_rsp_valid", 512'(bus.o_rsp_valid), 512'(m_resp));
      chk("m_rsp_err", 512'(bus.o_rsp_err), 512'(m_resp & m_err));
      if (m_resp) begin
        chk("m_rsp_id", 512'(bus.o_rsp_id), 512'(q[0].id));
        chk("m_rsp_data", 512'(bus.o_rsp_data),
            m_err ? 512'(0) : 512'(norm(q[0].v)));
      end
      resp_now = m_resp;
      if (bus.i_eng_valid) begin
        if (m_wait) begin
          m_wait = 0;
          m_resp = 1;
        end else begin
          m_spur = 1;
        end
      end
`ifdef RENORM_SCHED_TIMEOUT_EN
      else if (m_wait) begin
        if (m_cnt == TO - 1) begin
          m_wait = 0;
          m_resp = 1;
          m_err  = 1;
        end else begin
          m_cnt++;
        end
      end
`endif
      if (m_issue) begin
        m_issue = 0;
        m_wait  = 1;
        m_cnt   = 0;
      end
      if (resp_now && bus.i_rsp_ready) begin
        void'(q.pop_front());
        m_resp = 0;
        m_err  = 0;
      end
      if (g >= 0) begin
        q.push_back('{id: IDW'(g), v: bus.i_req_data[g]});
        m_ptr   = (g + 1) % NR;
        m_issue = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_req_ready"}, 512'(bus.o_req_ready), 512'(0));
    chk({nm, "_eng_valid"}, 512'(bus.o_eng_valid), 512'(0));
    chk({nm, "_eng_data"}, 512'(bus.o_eng_data), 512'(0));
    chk({nm, "_rsp_valid"}, 512'(bus.o_rsp_valid), 512'(0));
    chk({nm, "_rsp_id"}, 512'(bus.o_rsp_id), 512'(0));
    chk({nm, "_rsp_data"}, 512'(bus.o_rsp_data), 512'(0));
    chk({nm, "_rsp_err"}, 512'(bus.o_rsp_err), 512'(0));
    chk({nm, "_busy"}, 512'(bus.o_busy), 512'(0));
    chk({nm, "_err_spurious"}, 512'(bus.o_err_spurious), 512'(0));
  endtask

  task automatic wait_rsp(string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_rsp_valid) begin
      nvec++;
      nfail++;
      $display("FAIL %s: no response within 200 cycles", nm);
    end
  endtask

  task automatic wait_grant(string nm, output int g);
    int n;
    n = 0;
    g = -1;
    @(negedge clk);
    while (bus.o_req_ready == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < NR; i++) if (bus.o_req_ready[i]) g = i;
    if (g < 0) begin
      nvec++;
      nfail++;
      $display("FAIL %s: no grant within 200 cycles", nm);
    end
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_busy) begin
      nvec++;
      nfail++;
      $display("FAIL %s: still busy after 200 cycles", nm);
    end
  endtask

  initial begin
    vec_t lit;
    int   g;
    int   t0;
    int   cnt[NR];

    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request from requester 2, all elements 0x0800 (sum = 1.0).
    tick();
    for (int e = 0; e < N; e++) bus.i_req_data[2][e] = 16'h0800;
    bus.i_req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 512'(bus.o_req_ready), 512'(4'b0100));
    t0 = cyc;
    tick();
    bus.i_req_valid = '0;
    @(negedge clk);
    chk("single_eng_valid", 512'(bus.o_eng_valid), 512'(1));
    wait_rsp("single_rsp");
    chk("single_latency", 512'(cyc - t0), 512'(3));
    chk("single_id", 512'(bus.o_rsp_id), 512'(2));
    for (int e = 0; e < N; e++) lit[e] = 16'h0800;
    chk("single_data", 512'(bus.o_rsp_data), 512'(lit));
    tick();

    // Spurious done in IDLE, then a normal transaction from requester 0.
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_set", 512'(bus.o_err_spurious), 512'(1));
    repeat (3) tick();
    @(negedge clk);
    chk("spur_sticky", 512'(bus.o_err_spurious), 512'(1));
    tick();
    bus.i_req_data[0]    = '0;
    bus.i_req_data[0][0] = 16'h4000;
    bus.i_req_data[0][1] = 16'h4000;
    bus.i_req_valid      = 4'b0001;
    wait_grant("spur_grant", g);
    chk("spur_grant_id", 512'(g), 512'(0));
    tick();
    bus.i_req_valid = '0;
    wait_rsp("spur_rsp");
    lit = '0;
    lit[0] = 16'h8000;
    lit[1] = 16'h8000;
    chk("spur_rsp_data", 512'(bus.o_rsp_data), 512'(lit));
    chk("spur_rsp_id", 512'(bus.o_rsp_id), 512'(0));
    tick();

    // Backpressure: consumer stalls 10 cycles, requester 3 waits meanwhile.
    bus.i_rsp_ready    = 1'b0;
    bus.i_req_data[1]  = pat(1, 7);
    bus.i_req_data[3]  = pat(3, 7);
    bus.i_req_valid    = 4'b0010;
    wait_grant("bp_grant", g);
    chk("bp_grant_id", 512'(g), 512'(1));
    tick();
    bus.i_req_valid = 4'b1000;
    wait_rsp("bp_rsp");
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_valid", 512'(bus.o_rsp_valid), 512'(1));
      chk("bp_hold_id", 512'(bus.o_rsp_id), 512'(1));
      chk("bp_hold_data", 512'(bus.o_rsp_data), 512'(norm(pat(1, 7))));
      chk("bp_hold_ready", 512'(bus.o_req_ready), 512'(0));
      chk("bp_hold_eng", 512'(bus.o_eng_valid), 512'(0));
    end
    tick();
    bus.i_rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_next_grant", 512'(bus.o_req_ready), 512'(4'b1000));
    tick();
    bus.i_req_valid = '0;
    wait_rsp("bp_rsp3");
    chk("bp_rsp3_id", 512'(bus.o_rsp_id), 512'(3));
    tick();

    // Reset while waiting on the engine.
    eng_hang = 1'b1;
    bus.i_req_data[2] = pat(2, 9);
    bus.i_req_valid   = 4'b0100;
    wait_grant("rw_grant", g);
    chk("rw_grant_id", 512'(g), 512'(2));
    tick();
    bus.i_req_valid = '0;
    tick();
    @(negedge clk);
    chk("rw_in_wait", 512'(bus.o_busy), 512'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("rw");
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    eng_hang = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rw_no_rsp", 512'(bus.o_rsp_valid), 512'(0));
    end

    // Fairness: all four valid for eight transactions.
    tick();
    for (int k = 0; k < NR; k++) begin
      bus.i_req_data[k] = pat(k, 0);
      cnt[k] = 0;
    end
    bus.i_req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_grant("fair_grant", g);
      chk("fair_order", 512'(g), 512'(n % NR));
      if (g >= 0) begin
        cnt[g]++;
        tick();
        bus.i_req_data[g] = pat(g, n + 1);
        if (n == 7) bus.i_req_valid = '0;
      end
    end
    bus.i_req_valid = '0;
    wait_idle("fair_idle");
    for (int k = 0; k < NR; k++) chk("fair_count", 512'(cnt[k]), 512'(2));

    // A lone requester is granted every round.
    tick();
    bus.i_req_valid = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      wait_grant("solo_grant", g);
      chk("solo_id", 512'(g), 512'(1));
      tick();
      bus.i_req_data[1] = pat(1, n + 20);
    end
    bus.i_req_valid = '0;
    wait_idle("solo_idle");

    // Engine never answers.
    tick();
    eng_hang = 1'b1;
    bus.i_req_data[0] = pat(0, 30);
    bus.i_req_valid   = 4'b0001;
    wait_grant("to_grant", g);
    chk("to_grant_id", 512'(g), 512'(0));
    tick();
    bus.i_req_valid = '0;
    @(negedge clk);
    t0 = cyc;
`ifdef RENORM_SCHED_TIMEOUT_EN
    wait_rsp("to_rsp");
    chk("to_latency", 512'(cyc - t0), 512'(TO + 1));
    chk("to_err", 512'(bus.o_rsp_err), 512'(1));
    chk("to_data", 512'(bus.o_rsp_data), 512'(0));
    tick();
    @(negedge clk);
    chk("to_err_clear", 512'(bus.o_rsp_err), 512'(0));
    eng_hang = 1'b0;
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("hang_busy", 512'(bus.o_busy), 512'(1));
      chk("hang_no_rsp", 512'(bus.o_rsp_valid), 512'(0));
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    eng_hang = 1'b0;
`endif
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
